// File: rtl/reg_file_pkg.sv
// Shared constants and types for the register-file write scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package reg_file_pkg;

    localparam int REG_COUNT = 8;
    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 3;
    localparam int NUM_REQ   = 3;

    localparam int REQ_ALU   = 0;
    localparam int REQ_MEM   = 1;
    localparam int REQ_LINK  = 2;

    localparam int CNT_W     = 2;
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t CNT_MAX = cnt_t'(3);

    // Saturating-free next count: callers guarantee no overflow (reserve gated at CNT_MAX)
    // and no underflow (commit at zero is flagged, not applied).
    function automatic cnt_t cnt_next(input cnt_t cur, input logic inc, input logic dec);
        cnt_t nxt;
        nxt = cur;
        if (inc && !dec) begin
            nxt = cur + 1'b1;
        end else if (dec && !inc && (cur != '0)) begin
            nxt = cur - 1'b1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant with a rotating priority pointer.
// Latency: grant is combinational; pointer advances at the next edge.
// Backpressure: none; some valid request is granted every cycle.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    logic             found;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Scan from ptr upward with wrap; the first hit wins and the pointer moves past it.
    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr_q} + (PTR_W+1)'(i);
            if (sum >= (PTR_W+1)'(N)) begin
                sum = sum - (PTR_W+1)'(N);
            end
            idx = sum[PTR_W-1:0];
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                ptr_d      = (idx == PTR_W'(N-1)) ? '0 : idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_file_arbiter.sv
// Write-port scheduler for the 8x16 register file plus per-register pending-write scoreboard.
// Latency: grant in cycle N drives wrEn/wrDR/wrData in N+1; busy clears in N+2.
// Backpressure: regFile never stalls; requesters wait on reqReady, decode waits on reserveReady.
module reg_file_arbiter
    import reg_file_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 3
) (
    input  logic                      clk,
    input  logic                      rstN,
    input  logic [NUM_REQ-1:0]        reqValid,
    input  logic [NUM_REQ*ADDR_W-1:0] reqDR,
    input  logic [NUM_REQ*DATA_W-1:0] reqData,
    output logic [NUM_REQ-1:0]        reqReady,
    output logic                      wrEn,
    output logic [ADDR_W-1:0]         wrDR,
    output logic [DATA_W-1:0]         wrData,
    input  logic                      reserveValid,
    input  logic [ADDR_W-1:0]         reserveDR,
    output logic                      reserveReady,
    output logic [(1<<ADDR_W)-1:0]    busy,
    output logic                      errSticky
);

    localparam int NREG = 1 << ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] dr;
        logic [DATA_W-1:0] dat;
    } wr_req_t;

    logic [NUM_REQ-1:0] gnt;
    wr_req_t            sel;
    wr_req_t            wr_q, wr_d;
    logic               wr_en_q, wr_en_d;
    cnt_t               cnt_q [NREG];
    cnt_t               cnt_d [NREG];
    logic [NREG-1:0]    inc_v, dec_v;
    logic               err_q, err_d;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk_i  (clk),
        .rst_ni (rstN),
        .req_i  (reqValid),
        .gnt_o  (gnt)
    );

    assign reqReady = gnt;

    // Grant is one-hot, so an OR-style select of the winning slice is sufficient.
    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel.dr  = reqDR[i*ADDR_W +: ADDR_W];
                sel.dat = reqData[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        wr_en_d = |gnt;
        wr_d    = wr_q;
        if (|gnt) begin
            wr_d = sel;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wr_en_q <= 1'b0;
            wr_q    <= '0;
        end else begin
            wr_en_q <= wr_en_d;
            wr_q    <= wr_d;
        end
    end

    assign wrEn   = wr_en_q;
    assign wrDR   = wr_q.dr;
    assign wrData = wr_q.dat;

    assign reserveReady = reserveValid && (cnt_q[reserveDR] != CNT_MAX);

    always_comb begin
        inc_v = '0;
        dec_v = '0;
        for (int r = 0; r < NREG; r++) begin
            inc_v[r] = reserveReady && (reserveDR == ADDR_W'(r));
            dec_v[r] = wr_en_q && (wr_q.dr == ADDR_W'(r));
        end
    end

    // A commit with no matching reservation (and no same-cycle reserve to cancel it) is an error.
    always_comb begin
        err_d = err_q;
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = cnt_next(cnt_q[r], inc_v[r], dec_v[r]);
            if (dec_v[r] && !inc_v[r] && (cnt_q[r] == '0)) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            err_q <= err_d;
        end
    end

    always_comb begin
        busy = '0;
        for (int r = 0; r < NREG; r++) begin
            busy[r] = (cnt_q[r] != '0);
        end
    end

    assign errSticky = err_q;

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Self-checking bench for reg_file_arbiter: arbitration table, scoreboard queue on the write port,
// and directed sequences for reset abort, saturation, same-cycle reserve/commit and error latching.
module tb_reg_file_arbiter;

    logic        clk;
    logic        rstN;
    logic [2:0]  reqValid;
    logic [8:0]  reqDR;
    logic [47:0] reqData;
    logic [2:0]  reqReady;
    logic        wrEn;
    logic [2:0]  wrDR;
    logic [15:0] wrData;
    logic        reserveValid;
    logic [2:0]  reserveDR;
    logic        reserveReady;
    logic [7:0]  busy;
    logic        errSticky;

    logic [2:0]  bdr  [3];
    logic [15:0] bdat [3];
    logic [15:0] rf   [8];

    typedef struct {
        logic [2:0] vld;
        logic [2:0] exp_rdy;
    } vec_t;

    typedef struct packed {
        logic [2:0]  dr;
        logic [15:0] dat;
    } exp_t;

    vec_t tbl [12];
    exp_t q [$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    assign reqDR   = {bdr[2], bdr[1], bdr[0]};
    assign reqData = {bdat[2], bdat[1], bdat[0]};

    reg_file_arbiter #(.NUM_REQ(3), .DATA_W(16), .ADDR_W(3)) dut (
        .clk          (clk),
        .rstN         (rstN),
        .reqValid     (reqValid),
        .reqDR        (reqDR),
        .reqData      (reqData),
        .reqReady     (reqReady),
        .wrEn         (wrEn),
        .wrDR         (wrDR),
        .wrData       (wrData),
        .reserveValid (reserveValid),
        .reserveDR    (reserveDR),
        .reserveReady (reserveReady),
        .busy         (busy),
        .errSticky    (errSticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file as the DUT's consumer sees it.
    always @(posedge clk) begin
        if (wrEn) rf[wrDR] <= wrData;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(input int k);
        q.push_back(exp_t'{dr: bdr[k], dat: bdat[k]});
    endtask

    always @(negedge clk) begin
        if (rstN && wrEn) begin
            if (q.size() == 0) begin
                chk("sb_unexpected_wrEn", 32'(wrEn), 32'd0);
            end else begin
                mon_e = q.pop_front();
                chk("sb_wrDR", 32'(wrDR), 32'(mon_e.dr));
                chk("sb_wrData", 32'(wrData), 32'(mon_e.dat));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{3'b111, 3'b001};
        tbl[1]  = '{3'b111, 3'b010};
        tbl[2]  = '{3'b111, 3'b100};
        tbl[3]  = '{3'b111, 3'b001};
        tbl[4]  = '{3'b000, 3'b000};
        tbl[5]  = '{3'b101, 3'b100};
        tbl[6]  = '{3'b110, 3'b010};
        tbl[7]  = '{3'b011, 3'b001};
        tbl[8]  = '{3'b001, 3'b001};
        tbl[9]  = '{3'b100, 3'b100};
        tbl[10] = '{3'b010, 3'b010};
        tbl[11] = '{3'b100, 3'b100};

        rstN = 1'b0; reqValid = '0; reserveValid = 1'b0; reserveDR = '0;
        for (int k = 0; k < 3; k++) begin bdr[k] = '0; bdat[k] = '0; end
        #3;
        chk("rst_wrEn", 32'(wrEn), 0);
        chk("rst_wrDR", 32'(wrDR), 0);
        chk("rst_wrData", 32'(wrData), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(errSticky), 0);
        chk("rst_reqReady", 32'(reqReady), 0);
        repeat (2) @(posedge clk);
        #1 rstN = 1'b1;

        // Arbitration table: DRs 1,2,7 fixed per requester.
        bdr[0] = 3'd1; bdr[1] = 3'd2; bdr[2] = 3'd7;
        for (int s = 0; s < 12; s++) begin
            reqValid = tbl[s].vld;
            for (int k = 0; k < 3; k++) bdat[k] = 16'(10 * (k + 1) + 100 * s);
            #1;
            chk($sformatf("arb_step%0d", s), 32'(reqReady), 32'(tbl[s].exp_rdy));
            for (int k = 0; k < 3; k++) if (tbl[s].exp_rdy[k]) push_req(k);
            tick;
        end
        reqValid = '0;
        tick;
        tick;
        chk("err_after_unreserved_table", 32'(errSticky), 1);

        // Reset while a write is on the port.
        reserveValid = 1'b1; reserveDR = 3'd6;
        bdr[0] = 3'd6; bdat[0] = 16'd77; reqValid = 3'b001;
        tick;
        reserveValid = 1'b0; reqValid = '0;
        chk("pre_rst_wrEn", 32'(wrEn), 1);
        chk("pre_rst_busy6", 32'(busy[6]), 1);
        rstN = 1'b0;
        #1;
        chk("midrst_wrEn", 32'(wrEn), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_err", 32'(errSticky), 0);
        tick;
        tick;
        rstN = 1'b1;
        reqValid = 3'b111;
        #1;
        chk("post_rst_grant", 32'(reqReady), 32'b001);
        reqValid = '0;
        #1;

        // Single write through MEM to R3.
        reserveValid = 1'b1; reserveDR = 3'd3;
        #1;
        chk("rsv_r3_ready", 32'(reserveReady), 1);
        tick;
        reserveValid = 1'b0;
        chk("busy3_after_rsv", 32'(busy[3]), 1);
        bdr[1] = 3'd3; bdat[1] = 16'd500; reqValid = 3'b010;
        #1;
        chk("mem_grant", 32'(reqReady), 32'b010);
        push_req(1);
        tick;
        reqValid = '0;
        chk("single_wrEn", 32'(wrEn), 1);
        chk("single_wrDR", 32'(wrDR), 3);
        chk("single_wrData", 32'(wrData), 500);
        chk("single_busy3_n1", 32'(busy[3]), 1);
        tick;
        chk("single_busy3_n2", 32'(busy[3]), 0);
        chk("single_wrEn_off", 32'(wrEn), 0);
        chk("single_rf3", 32'(rf[3]), 500);

        // Scoreboard saturation on R5.
        reserveValid = 1'b1; reserveDR = 3'd5;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("sat_rsv%0d", i), 32'(reserveReady), 1);
            tick;
        end
        #1;
        chk("sat_rsv_full", 32'(reserveReady), 0);
        chk("sat_busy5", 32'(busy[5]), 1);
        tick;
        reserveValid = 1'b0;
        bdr[0] = 3'd5; bdat[0] = 16'd55; reqValid = 3'b001;
        #1;
        chk("sat_alu_grant", 32'(reqReady), 32'b001);
        push_req(0);
        tick;
        reqValid = '0;
        tick;
        reserveValid = 1'b1;
        #1;
        chk("sat_rsv_after_commit", 32'(reserveReady), 1);
        tick;
        #1;
        chk("sat_full_again", 32'(reserveReady), 0);
        reserveValid = 1'b0;
        reqValid = 3'b001;
        for (int i = 0; i < 3; i++) begin
            bdat[0] = 16'(60 + i);
            #1;
            push_req(0);
            tick;
        end
        reqValid = '0;
        tick;
        tick;
        chk("sat_drain_busy", 32'(busy), 0);
        chk("sat_drain_err", 32'(errSticky), 0);

        // Same-cycle reserve and commit on R2 with one outstanding.
        reserveValid = 1'b1; reserveDR = 3'd2;
        tick;
        reserveValid = 1'b0;
        bdr[1] = 3'd2; bdat[1] = 16'd222; reqValid = 3'b010;
        #1;
        push_req(1);
        tick;
        reqValid = '0;
        reserveValid = 1'b1; reserveDR = 3'd2;
        #1;
        chk("simul_rsv_ready", 32'(reserveReady), 1);
        tick;
        reserveValid = 1'b0;
        chk("simul_busy2", 32'(busy[2]), 1);
        chk("simul_err", 32'(errSticky), 0);
        tick;
        chk("simul_busy2_hold", 32'(busy[2]), 1);
        bdat[1] = 16'd223; reqValid = 3'b010;
        #1;
        push_req(1);
        tick;
        reqValid = '0;
        tick;
        chk("simul_busy2_clear", 32'(busy[2]), 0);
        chk("simul_err_final", 32'(errSticky), 0);

        // Unreserved write to R4 sets and latches the error.
        bdr[0] = 3'd4; bdat[0] = 16'd444; reqValid = 3'b001;
        #1;
        push_req(0);
        tick;
        reqValid = '0;
        tick;
        chk("unrsv_err", 32'(errSticky), 1);
        chk("unrsv_busy4", 32'(busy[4]), 0);
        repeat (3) tick;
        chk("unrsv_err_latched", 32'(errSticky), 1);

        // Back-to-back writes of 300 to every register through the ALU port.
        rstN = 1'b0;
        #1 rstN = 1'b1;
        chk("err_cleared_by_rst", 32'(errSticky), 0);
        reserveValid = 1'b1;
        for (int r = 0; r < 8; r++) begin
            reserveDR = 3'(r);
            #1;
            chk($sformatf("all_rsv%0d", r), 32'(reserveReady), 1);
            tick;
        end
        reserveValid = 1'b0;
        chk("all_busy_ff", 32'(busy), 32'hff);
        reqValid = 3'b001;
        for (int r = 0; r < 8; r++) begin
            bdr[0] = 3'(r); bdat[0] = 16'd300;
            #1;
            push_req(0);
            tick;
            chk($sformatf("all_wrEn%0d", r), 32'(wrEn), 1);
            chk($sformatf("all_wrDR%0d", r), 32'(wrDR), 32'(r));
        end
        reqValid = '0;
        tick;
        tick;
        chk("all_busy_zero", 32'(busy), 0);
        chk("all_err", 32'(errSticky), 0);
        for (int r = 0; r < 8; r++) begin
            chk($sformatf("all_rf%0d", r), 32'(rf[r]), 300);
        end

        chk("sb_queue_empty", 32'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
